sha256_core: RTL and testbench

SHA-256/SHA-224 compression engine that processes one pre-padded 512-bit block per command. `init` starts a new hash from the mode IV; `next` chains another block onto the running hash state. Padding and length encoding are done upstream. Host logic drives it with single-cycle pulses and polls `ready` and `digest_valid`.

---
 rtl/sha256_pkg.sv | 75 +++++++
 rtl/sha256_w_mem.sv | 36 +++
 rtl/sha256_core.sv | 115 +++++++++++
 tb/tb_sha256_core.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and the SHA-2 bit-mixing helpers.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUNDS,
        ST_DONE
    } state_e;

    // Round constants, K[0] is the leftmost word.
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash values, H0 leftmost (matches digest packing).
    localparam logic [0:7][31:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:7][31:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    // Rotate right; n is always a nonzero constant at the call sites.
    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Compression-side sigma on a.
    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    // Compression-side sigma on e.
    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    // Message-schedule sigmas.
    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_mem.sv
// Sliding 16-word message schedule. Word 15 of the window is always W[t];
// each advance drops it and appends W[t+16].
module sha256_w_mem
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [511:0] block_i,
    input  logic         advance_i,
    output logic [31:0]  w_o
);

    // w_q[15-k] holds W[t+k]; loading the block directly puts W0 at index 15.
    logic [15:0][31:0] w_q;
    logic [31:0]       w_new;

    assign w_o = w_q[15];

    // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    always_comb begin
        w_new = small_s1(w_q[1]) + w_q[6] + small_s0(w_q[14]) + w_q[15];
    end

    // Window load on command acceptance, shift once per round.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= '0;
        end else if (load_i) begin
            w_q <= block_i;
        end else if (advance_i) begin
            w_q <= {w_q[14:0], w_new};
        end
    end

endmodule

// File: rtl/sha256_core.sv
// SHA-256 / SHA-224 single-block compression engine, one round per clock.
// IDLE accepts init/next, ROUNDS runs 64 rounds, DONE folds the working
// variables into H and raises digest_valid.
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    state_e           state_q;
    logic [5:0]       rnd_q;
    logic             ready_q;
    logic             dv_q;
    logic             mode_q;
    logic [0:7][31:0] h_q;
    logic [31:0]      a_q, b_q, c_q, d_q, e_q, f_q, g_q, hh_q;

    logic             accept;
    logic             advance;
    logic [31:0]      w_t;
    logic [31:0]      t1, t2;
    logic [31:0]      a_d, e_d;
    logic [0:7][31:0] iv_sel;

    assign accept  = (state_q == ST_IDLE) && (init || next);
    assign advance = (state_q == ST_ROUNDS);

    assign ready        = ready_q;
    assign digest_valid = dv_q;
    assign digest       = h_q;

    sha256_w_mem u_w_mem (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .block_i   (block),
        .advance_i (advance),
        .w_o       (w_t)
    );

    // Round datapath and IV selection; a fresh init uses the incoming mode,
    // otherwise the mode latched for the current message.
    always_comb begin
        t1     = hh_q + big_s1(e_q) + ch(e_q, f_q, g_q) + K[rnd_q] + w_t;
        t2     = big_s0(a_q) + maj(a_q, b_q, c_q);
        a_d    = t1 + t2;
        e_d    = d_q + t1;
        iv_sel = (init ? mode : mode_q) ? IV256 : IV224;
    end

    // Control FSM with registered handshake outputs, working vars and H.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            ready_q <= 1'b1;
            dv_q    <= 1'b0;
            mode_q  <= 1'b1;
            h_q     <= '0;
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, hh_q} <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init || next) begin
                        ready_q <= 1'b0;
                        dv_q    <= 1'b0;
                        rnd_q   <= '0;
                        state_q <= ST_ROUNDS;
                        if (init) begin
                            mode_q <= mode;
                            h_q    <= iv_sel;
                            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, hh_q} <= iv_sel;
                        end else begin
                            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, hh_q} <= h_q;
                        end
                    end
                end
                ST_ROUNDS: begin
                    hh_q  <= g_q;
                    g_q   <= f_q;
                    f_q   <= e_q;
                    e_q   <= e_d;
                    d_q   <= c_q;
                    c_q   <= b_q;
                    b_q   <= a_q;
                    a_q   <= a_d;
                    rnd_q <= rnd_q + 6'd1;
                    if (rnd_q == 6'd63) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    h_q <= {h_q[0] + a_q, h_q[1] + b_q, h_q[2] + c_q, h_q[3] + d_q,
                            h_q[4] + e_q, h_q[5] + f_q, h_q[6] + g_q, h_q[7] + hh_q};
                    dv_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: known vectors, handshake corner
// cases and random init/next traffic against a whole-block reference model.
module tb_sha256_core;

    logic         clk;
    logic         reset;
    logic         init;
    logic         next;
    logic         mode;
    logic [511:0] block;
    logic         ready;
    logic [255:0] digest;
    logic         digest_valid;

    int checks = 0;
    int errors = 0;

    logic [255:0] m_H;
    logic         m_mode;

    localparam logic [255:0] TB_IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] TB_IV224 =
        256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_core dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .next         (next),
        .mode         (mode),
        .block        (block),
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full-block compression with the whole 64-word schedule expanded up front.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] b);
        logic [31:0] W [64];
        logic [31:0] H [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++)  H[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 16; i++) W[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            W[i] = (rr(W[i-2], 17) ^ rr(W[i-2], 19) ^ (W[i-2] >> 10)) + W[i-7]
                 + (rr(W[i-15], 7) ^ rr(W[i-15], 18) ^ (W[i-15] >> 3)) + W[i-16];
        v = H;
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + W[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = H[i] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Present a command for one edge, then scramble the inputs. Model is
    // updated with what an accepted command should do.
    task automatic issue(input bit i_init, input bit i_next, input bit i_mode, input logic [511:0] b);
        init  = i_init;
        next  = i_next;
        mode  = i_mode;
        block = b;
        @(posedge clk); #1;
        init  = 1'b0;
        next  = 1'b0;
        mode  = 1'($urandom);
        block = rand_block();
        if (i_init) begin
            m_mode = i_mode;
            m_H    = ref_compress(i_mode ? TB_IV256 : TB_IV224, b);
        end else if (i_next) begin
            m_H = ref_compress(m_H, b);
        end
    endtask

    // Count cycles with ready low, bounded so a stuck DUT cannot hang us.
    task automatic wait_ready(output int lowcnt);
        lowcnt = 0;
        while (ready !== 1'b1 && lowcnt < 200) begin
            lowcnt++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; init = 1'b0; next = 1'b0; mode = 1'b0; block = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_H = '0; m_mode = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", digest_valid); end
        checks++; if (digest !== 256'h0) begin errors++; $display("FAIL reset_digest got %h want 0", digest); end
    endtask

    task automatic test_abc();
        int lc;
        logic [511:0] abc;
        abc = {32'h61626380, 416'h0, 64'h18};
        issue(1'b1, 1'b0, 1'b1, abc);
        wait_ready(lc);
        checks++; if (lc != 65) begin errors++; $display("FAIL abc256_lat got %0d want 65", lc); end
        checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL abc256_dv got %b want 1", digest_valid); end
        checks++;
        if (digest !== 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad) begin
            errors++; $display("FAIL abc256_digest got %h want ba7816bf...f20015ad", digest);
        end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL abc256_model got %h want %h", digest, m_H); end

        issue(1'b1, 1'b0, 1'b0, abc);
        wait_ready(lc);
        checks++;
        if (digest[255:32] !== 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7) begin
            errors++; $display("FAIL abc224_digest got %h want 23097d22...e36c9da7", digest[255:32]);
        end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL abc224_model got %h want %h", digest, m_H); end
    endtask

    task automatic test_chain();
        int lc;
        issue(1'b1, 1'b0, 1'b1, {48'h68656c6c6f80, 400'h0, 64'h28});
        wait_ready(lc);
        checks++; if (digest !== m_H) begin errors++; $display("FAIL chain_blk1 got %h want %h", digest, m_H); end
        // mode=0 on next must not switch the running hash to SHA-224
        issue(1'b0, 1'b1, 1'b0, {64'h6d65737361676532, 384'h0, 64'h28});
        wait_ready(lc);
        checks++;
        if (digest !== 256'h09c99d8f65c1283923c1a8ffa779c3fb76943715bc61d2c93a42030dd1008130) begin
            errors++; $display("FAIL chain_digest got %h want 09c99d8f...d1008130", digest);
        end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL chain_model got %h want %h", digest, m_H); end
    endtask

    task automatic test_timing();
        int lc;
        // digest_valid is high from the previous test
        issue(1'b0, 1'b1, 1'b1, rand_block());
        checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL timing_dv_drop got %b want 0", digest_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL timing_ready_drop got %b want 0", ready); end
        wait_ready(lc);
        checks++; if (lc != 65) begin errors++; $display("FAIL timing_low_cycles got %0d want 65", lc); end
        checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL timing_dv_rise got %b want 1", digest_valid); end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL timing_digest got %h want %h", digest, m_H); end
        // digest held while idle
        repeat (5) @(posedge clk);
        #1;
        checks++; if (digest !== m_H) begin errors++; $display("FAIL timing_hold got %h want %h", digest, m_H); end
    endtask

    task automatic test_ignore_busy();
        int lc;
        issue(1'b1, 1'b0, 1'b1, rand_block());
        repeat (10) @(posedge clk);
        #1;
        next = 1'b1; block = rand_block();
        @(posedge clk); #1;
        next = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        init = 1'b1; mode = 1'b0; block = rand_block();
        @(posedge clk); #1;
        init = 1'b0;
        wait_ready(lc);
        checks++; if (lc != 65 - 17) begin errors++; $display("FAIL busy_low_cycles got %0d want 48", lc); end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL busy_digest got %h want %h", digest, m_H); end
    endtask

    task automatic test_init_next_both();
        int lc;
        issue(1'b1, 1'b1, 1'b0, rand_block());
        wait_ready(lc);
        checks++; if (digest !== m_H) begin errors++; $display("FAIL both_digest got %h want %h", digest, m_H); end
    endtask

    task automatic test_back_to_back();
        int lc1, lc2;
        issue(1'b1, 1'b0, 1'b1, rand_block());
        wait_ready(lc1);
        checks++; if (digest !== m_H) begin errors++; $display("FAIL b2b_first got %h want %h", digest, m_H); end
        issue(1'b1, 1'b0, 1'b0, rand_block());
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready %b want 0", ready); end
        wait_ready(lc2);
        checks++; if (lc2 != 65) begin errors++; $display("FAIL b2b_low_cycles got %0d want 65", lc2); end
        checks++; if (digest !== m_H) begin errors++; $display("FAIL b2b_second got %h want %h", digest, m_H); end
    endtask

    task automatic test_reset_mid_rounds();
        int lc;
        issue(1'b1, 1'b0, 1'b1, rand_block());
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_H = '0; m_mode = 1'b1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready); end
        checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL midrst_dv got %b want 0", digest_valid); end
        checks++; if (digest !== 256'h0) begin errors++; $display("FAIL midrst_digest got %h want 0", digest); end
        // next straight after reset compresses onto H = 0
        issue(1'b0, 1'b1, 1'b0, rand_block());
        wait_ready(lc);
        checks++; if (digest !== m_H) begin errors++; $display("FAIL next_from_zero got %h want %h", digest, m_H); end
    endtask

    task automatic test_random();
        int lc;
        bit op, md;
        for (int i = 0; i < 12; i++) begin
            op = 1'($urandom);
            md = 1'($urandom);
            if (op) issue(1'b1, 1'($urandom), md, rand_block());
            else    issue(1'b0, 1'b1, md, rand_block());
            wait_ready(lc);
            checks++; if (lc != 65) begin errors++; $display("FAIL rand%0d_lat got %0d want 65", i, lc); end
            checks++; if (digest !== m_H) begin errors++; $display("FAIL rand%0d_digest got %h want %h", i, digest, m_H); end
            // random idle gap before the next command
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_chain();
        test_timing();
        test_ignore_busy();
        test_init_next_both();
        test_back_to_back();
        test_reset_mid_rounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
